// File: rtl/shift_add_multiplier.sv
// Signed WIDTH x WIDTH -> 2*WIDTH multiplier, one shift-add step per clock, sign-magnitude internally.
// Latency: start edge k -> done pulse in the cycle after edge k+WIDTH+1 (early exit shortens RUN).
// Backpressure: start is taken only in IDLE with done low; busy covers the whole operation.
// Optional: define MUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are all zero.
module shift_add_multiplier #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand;   // |A|
  // Upper half is the partial-sum accumulator; the lower half starts as |B| and
  // fills with finished product bits as the multiplier bits are shifted out.
  logic [2*WIDTH-1:0] acc;
  logic               neg;
  logic [CW-1:0]      count;   // RUN steps still to do, including the current one

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     sum;     // accumulator add with its carry bit
  logic [2*WIDTH-1:0] stepped;
  logic [2*WIDTH-1:0] signed_prod;

  // Operand magnitudes, one add-and-shift step, and the final sign fix-up
  always_comb begin
    a_mag       = multiplicand[WIDTH-1] ? (~multiplicand + WIDTH'(1)) : multiplicand;
    b_mag       = multiplier[WIDTH-1]   ? (~multiplier   + WIDTH'(1)) : multiplier;
    sum         = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    stepped     = {sum, acc[WIDTH-1:1]};
    signed_prod = neg ? (~acc + (2*WIDTH)'(1)) : acc;
  end

`ifdef MUL_EARLY_EXIT_EN
  logic [WIDTH-1:0] rem_mask;
  logic             rem_zero;

  // After this step, count-1 multiplier bits remain; if all are zero the rest
  // of the run would only shift, so do that shift in one go.
  always_comb begin
    rem_mask = (WIDTH'(1) << (count - CW'(1))) - WIDTH'(1);
    rem_zero = (((acc[WIDTH-1:0] >> 1) & rem_mask) == '0);
  end
`endif

  // Control FSM with registered handshake and product outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      mcand      <= '0;
      acc        <= '0;
      neg        <= 1'b0;
      count      <= '0;
      product_hi <= '0;
      product_lo <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          // The done cycle still belongs to the finishing operation, so a start
          // seen alongside done is dropped.
          if (start && !done) begin
            mcand <= a_mag;
            acc   <= {{WIDTH{1'b0}}, b_mag};
            neg   <= multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
            count <= CW'(WIDTH);
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            acc   <= stepped;
            state <= FINISH;
          end else begin
`ifdef MUL_EARLY_EXIT_EN
            if (rem_zero) begin
              acc   <= stepped >> (count - CW'(1));
              state <= FINISH;
            end else begin
              acc <= stepped;
            end
`else
            acc <= stepped;
`endif
          end
        end
        FINISH: begin
          {product_hi, product_lo} <= signed_prod;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: signed products and latency against a plain-arithmetic model.
// Covers reset, fixed corner operands, random operands, ignored starts, held start and mid-operation reset.
// Inputs are driven 1 time unit after the rising edge and outputs are sampled at the same point.
module tb_shift_add_multiplier;

  localparam int W = 64;
`ifdef MUL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a, b;
  logic [W-1:0] hi, lo;
  logic         busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .multiplicand(a), .multiplier(b),
    .product_hi(hi), .product_lo(lo),
    .busy(busy), .done(done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: exact signed product of the sign-extended operands.
  function automatic logic [2*W-1:0] model_prod(input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [2*W-1:0] sx, sy;
    sx = {{W{x[W-1]}}, x};
    sy = {{W{y[W-1]}}, y};
    return sx * sy;
  endfunction

  // Edges from the start-sampling edge to the edge that raises done.
  // Early exit: one RUN cycle per multiplier bit up to the top set bit of |B|, at least one.
  function automatic int model_lat(input logic [W-1:0] y);
    logic [W-1:0] m;
    int runs;
    m = y[W-1] ? (~y + 1'b1) : y;
    runs = 1;
    for (int i = 0; i < W; i++) if (m[i]) runs = i + 1;
    return EARLY ? runs + 1 : W + 1;
  endfunction

  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y);
    a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits for done (bounded); flags any output change before done.
  task automatic wait_done(input logic [2*W-1:0] prev, output int lat, output bit moved);
    lat = 0;
    moved = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      tick();
      if (done) begin
        lat = n;
        break;
      end
      if ({hi, lo} !== prev) moved = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    tick(); tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if ({hi, lo} !== '0) begin n_fail++; $display("FAIL reset_product: got %h_%h want 0", hi, lo); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    int lat; bit moved;
    launch(64'd7, 64'd6);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
    wait_done('0, lat, moved);
    n_checks++; if (lat !== model_lat(64'd6)) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", lat, model_lat(64'd6)); end
    n_checks++; if ({hi, lo} !== model_prod(64'd7, 64'd6)) begin n_fail++; $display("FAIL basic_product: got %h_%h want %h", hi, lo, model_prod(64'd7, 64'd6)); end
    n_checks++; if (moved) begin n_fail++; $display("FAIL basic_hold: outputs changed before done"); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %b want 0", busy); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    n_checks++; if (lo !== 64'd42) begin n_fail++; $display("FAIL basic_held: got %h want 2a", lo); end
  endtask

  task automatic test_signed;
    logic [W-1:0] ta [8];
    logic [W-1:0] tb [8];
    logic [W-1:0] x, y;
    logic [2*W-1:0] prev, exp_p;
    int lat; bit moved;
    ta[0] = -64'sd3;               tb[0] = 64'd5;
    ta[1] = -64'sd3;               tb[1] = -64'sd5;
    ta[2] = 64'h8000000000000000;  tb[2] = 64'h8000000000000000;
    ta[3] = 64'h8000000000000000;  tb[3] = 64'd1;
    ta[4] = 64'd0;                 tb[4] = -64'sd7;
    ta[5] = -64'sd1;               tb[5] = -64'sd1;
    ta[6] = 64'd1234;              tb[6] = 64'd1;
    ta[7] = -64'sd9;               tb[7] = 64'd0;
    for (int i = 0; i < 24; i++) begin
      if (i < 8) begin
        x = ta[i]; y = tb[i];
      end else begin
        x = {$urandom, $urandom};
        if ($urandom_range(0, 2) == 0) begin
          y = W'($urandom_range(0, 300));
          if ($urandom_range(0, 1) == 1) y = ~y + 1'b1;
        end else begin
          y = {$urandom, $urandom};
        end
      end
      prev = {hi, lo};
      exp_p = model_prod(x, y);
      launch(x, y);
      wait_done(prev, lat, moved);
      n_checks++; if ({hi, lo} !== exp_p) begin n_fail++; $display("FAIL signed_product[%0d]: a=%h b=%h got %h_%h want %h", i, x, y, hi, lo, exp_p); end
      n_checks++; if (lat !== model_lat(y)) begin n_fail++; $display("FAIL signed_latency[%0d]: got %0d want %0d", i, lat, model_lat(y)); end
      n_checks++; if (moved) begin n_fail++; $display("FAIL signed_hold[%0d]: outputs changed before done", i); end
      tick();
    end
  endtask

  task automatic test_busy_ignore;
    int lat, j, exp_lat; bit moved; bit extra;
    exp_lat = model_lat(64'd3);
    j = (exp_lat - 1 < 10) ? exp_lat - 1 : 10;
    launch(64'd2, 64'd3);
    for (int n = 1; n < j; n++) tick();
    a = 64'd9; b = 64'd9; start = 1'b1;
    tick();
    start = 1'b0; a = '0; b = '0;
    wait_done({hi, lo}, lat, moved);
    n_checks++; if (lat + j !== exp_lat) begin n_fail++; $display("FAIL ignore_latency: got %0d want %0d", lat + j, exp_lat); end
    n_checks++; if ({hi, lo} !== model_prod(64'd2, 64'd3)) begin n_fail++; $display("FAIL ignore_product: got %h_%h want 6", hi, lo); end
    extra = 1'b0;
    for (int n = 0; n < W + 8; n++) begin
      tick();
      if (done || busy) extra = 1'b1;
    end
    n_checks++; if (extra) begin n_fail++; $display("FAIL ignore_no_second_op: got activity want idle"); end
  endtask

  task automatic test_back_to_back;
    int lat; bit moved;
    a = 64'd2; b = 64'd3; start = 1'b1;
    tick();
    wait_done({hi, lo}, lat, moved);
    n_checks++; if (lat !== model_lat(64'd3)) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want %0d", lat, model_lat(64'd3)); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_at_done: got %b want 0", busy); end
    wait_done({hi, lo}, lat, moved);
    start = 1'b0;
    n_checks++; if (lat !== model_lat(64'd3) + 2) begin n_fail++; $display("FAIL b2b_second_latency: got %0d want %0d", lat, model_lat(64'd3) + 2); end
    n_checks++; if ({hi, lo} !== model_prod(64'd2, 64'd3)) begin n_fail++; $display("FAIL b2b_product: got %h_%h want 6", hi, lo); end
    tick(); tick();
  endtask

  task automatic test_reset_midop;
    int lat, j; bit moved; bit seen;
    j = (model_lat(64'd5) - 1 < 20) ? model_lat(64'd5) - 1 : 20;
    launch(64'd5, 64'd5);
    for (int n = 1; n < j; n++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy); end
    n_checks++; if ({hi, lo} !== '0) begin n_fail++; $display("FAIL midreset_product: got %h_%h want 0", hi, lo); end
    seen = 1'b0;
    for (int n = 0; n < W + 8; n++) begin
      tick();
      if (done) seen = 1'b1;
    end
    n_checks++; if (seen) begin n_fail++; $display("FAIL midreset_no_done: got done want none"); end
    launch(64'd4, 64'd4);
    wait_done('0, lat, moved);
    n_checks++; if ({hi, lo} !== model_prod(64'd4, 64'd4)) begin n_fail++; $display("FAIL midreset_next_product: got %h_%h want 10", hi, lo); end
    n_checks++; if (lat !== model_lat(64'd4)) begin n_fail++; $display("FAIL midreset_next_latency: got %0d want %0d", lat, model_lat(64'd4)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
